// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and
// the fixed length-header size of the byte stream.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam int HDR_BYTES = 2;

endpackage

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian word stream into instruction memory
// and releases the CPU from reset once a complete program has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_en,
  output logic [ADDR_W-1:0] pc_in,
  output logic [31:0]       data_in,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t              state_q, state_d;
  logic [7:0]          len_lo_q;
  logic [ADDR_W:0]     last_q;     // N-1, one bit wider so N = DEPTH never wraps
  logic [ADDR_W:0]     idx_q;
  logic [1:0]          bcnt_q;
  logic [31:0]         word_q;
  logic [31:0]         data_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                im_en_q;
  logic                done_q;

  logic                xfer;
  logic                hdr_ok;
  logic                last_word;
  logic [15:0]         n_hdr;

  assign in_ready  = (state_q == LEN0) || (state_q == LEN1) || (state_q == DATA);
  assign xfer      = in_valid && in_ready;
  assign n_hdr     = {in_data, len_lo_q};
  assign hdr_ok    = (n_hdr != 16'd0) && ({1'b0, n_hdr} <= 17'(DEPTH));
  assign last_word = (idx_q == last_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) state_d = LEN0;
      LEN0:            if (xfer) state_d = LEN1;
      LEN1:            if (xfer) state_d = hdr_ok ? DATA : ERR;
      DATA:            if (xfer && bcnt_q == 2'd3) state_d = WRITE;
      WRITE:           state_d = last_word ? DONE : DATA;
      default:         state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo_q <= '0;
      last_q   <= '0;
      idx_q    <= '0;
      bcnt_q   <= '0;
      word_q   <= '0;
      data_q   <= '0;
      pc_q     <= '0;
      im_en_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      im_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            idx_q  <= '0;
            bcnt_q <= '0;
          end
        end
        LEN0: if (xfer) len_lo_q <= in_data;
        LEN1: if (xfer) last_q <= (ADDR_W+1)'(n_hdr - 16'd1);
        DATA: begin
          if (xfer) begin
            word_q <= {in_data, word_q[31:8]};
            bcnt_q <= bcnt_q + 2'd1;
            // Publish the word on the memory port as it completes so the
            // write strobe lands exactly in WRITE.
            if (bcnt_q == 2'd3) begin
              data_q  <= {in_data, word_q[31:8]};
              pc_q    <= idx_q[ADDR_W-1:0];
              im_en_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          bcnt_q <= '0;
          if (last_word) done_q <= 1'b1;
          else           idx_q  <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign im_en     = im_en_q;
  assign pc_in     = pc_q;
  assign data_in   = data_q;
  assign done      = done_q;
  assign error     = (state_q == ERR);
  assign cpu_rst_n = (state_q == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: vector table of complete loads plus
// hand sequences for reset, the DEPTH bound and reset mid-load.
module tb_imem_loader;

  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              rst, start, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, im_en, cpu_rst_n, done, error;
  logic [ADDR_W-1:0] pc_in;
  logic [31:0]       data_in;

  int checks = 0;
  int failures = 0;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_en(im_en), .pc_in(pc_in), .data_in(data_in),
    .cpu_rst_n(cpu_rst_n), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // write/done monitor
  logic [ADDR_W-1:0] wr_pc[$];
  logic [31:0]       wr_d[$];
  int                done_cnt = 0;
  logic              cpu_at_done = 1'b0;

  always @(negedge clk) begin
    if (im_en === 1'b1) begin
      wr_pc.push_back(pc_in);
      wr_d.push_back(data_in);
    end
    if (done === 1'b1) begin
      done_cnt++;
      cpu_at_done = cpu_rst_n;
    end
  end

  typedef struct {
    string            name;
    logic [0:11][7:0] b;
    int               nb;
    bit               gaps;
    bit               exp_err;
    int               exp_nw;
    logic [31:0]      w0;
    logic [31:0]      w1;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_pc.delete();
    wr_d.delete();
    done_cnt = 0;
    cpu_at_done = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Present a byte (after an optional gap) and hold it until it transfers.
  task automatic send_byte(input logic [7:0] v, input int gap);
    repeat (gap) begin
      @(negedge clk); in_valid = 1'b0; in_data = 8'($urandom);
    end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); in_valid = 1'b1; in_data = v;
      if (in_ready) begin
        @(posedge clk);
        return;
      end
    end
    checks++; failures++;
    $display("FAIL send_timeout: byte %0h never accepted", v);
  endtask

  task automatic wait_end();
    @(negedge clk); in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done_cnt > 0 || error) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    vt[0] = '{"two_word", {8'h02,8'h00,8'h93,8'h81,8'h26,8'h02,8'h93,8'h0E,8'h60,8'h0C,8'h00,8'h00},
              10, 1'b0, 1'b0, 2, 32'h02268193, 32'h0C600E93};
    vt[1] = '{"two_word_gaps", {8'h02,8'h00,8'h93,8'h81,8'h26,8'h02,8'h93,8'h0E,8'h60,8'h0C,8'h00,8'h00},
              10, 1'b1, 1'b0, 2, 32'h02268193, 32'h0C600E93};
    vt[2] = '{"n0_err", {8'h00,8'h00,80'h0}, 2, 1'b0, 1'b1, 0, 32'h0, 32'h0};
    vt[3] = '{"one_word", {8'h01,8'h00,8'hEF,8'hBE,8'hAD,8'hDE,48'h0}, 6, 1'b1, 1'b0, 1, 32'hDEADBEEF, 32'h0};
    vt[4] = '{"n513_err", {8'h01,8'h02,80'h0}, 2, 1'b0, 1'b1, 0, 32'h0, 32'h0};

    rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 8'hFF;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_im_en", im_en, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_cpu_rst_n", cpu_rst_n, 0);
    chk("rst_pc_in", pc_in, 0);
    chk("rst_data_in", data_in, 0);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_no_write", wr_d.size(), 0);
    in_valid = 1'b0;

    for (int v = 0; v < 5; v++) begin
      clear_log();
      do_start();
      chk({vt[v].name, "_start_error"}, error, 0);
      chk({vt[v].name, "_start_cpu"}, cpu_rst_n, 0);
      for (int i = 0; i < vt[v].nb; i++)
        send_byte(vt[v].b[i], vt[v].gaps ? int'($urandom_range(0, 3)) : 0);
      wait_end();
      chk({vt[v].name, "_error"}, error, vt[v].exp_err);
      chk({vt[v].name, "_in_ready"}, in_ready, 0);
      chk({vt[v].name, "_nwrites"}, wr_d.size(), vt[v].exp_nw);
      chk({vt[v].name, "_done_cnt"}, done_cnt, vt[v].exp_err ? 0 : 1);
      chk({vt[v].name, "_cpu_rst_n"}, cpu_rst_n, !vt[v].exp_err);
      if (!vt[v].exp_err)
        chk({vt[v].name, "_cpu_at_done"}, cpu_at_done, 1);
      if (wr_d.size() > 0 && vt[v].exp_nw > 0) begin
        chk({vt[v].name, "_pc0"}, wr_pc[0], 0);
        chk({vt[v].name, "_w0"}, wr_d[0], vt[v].w0);
      end
      if (wr_d.size() > 1 && vt[v].exp_nw > 1) begin
        chk({vt[v].name, "_pc1"}, wr_pc[1], 1);
        chk({vt[v].name, "_w1"}, wr_d[1], vt[v].w1);
      end
    end

    // N = DEPTH: full memory, index must reach 511 without wrapping
    begin
      int bad;
      logic [31:0] w;
      clear_log();
      do_start();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      for (int i = 0; i < 512; i++) begin
        w = {8'(i), 8'h5A, 8'(i >> 8), 8'(i ^ 8'hC3)};
        for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8], 0);
      end
      wait_end();
      chk("n512_nwrites", wr_d.size(), 512);
      chk("n512_last_pc", wr_pc.size() > 0 ? wr_pc[wr_pc.size()-1] : '1, 511);
      chk("n512_done_cnt", done_cnt, 1);
      chk("n512_cpu_rst_n", cpu_rst_n, 1);
      bad = 0;
      for (int i = 0; i < wr_d.size(); i++) begin
        w = {8'(i), 8'h5A, 8'(i >> 8), 8'(i ^ 8'hC3)};
        if (wr_d[i] !== w || wr_pc[i] !== ADDR_W'(i)) bad++;
      end
      chk("n512_data_mismatches", bad, 0);
    end

    // reset after 6 data bytes, then a fresh one-word load
    clear_log();
    do_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    send_byte(8'h44, 0); send_byte(8'h55, 0); send_byte(8'h66, 0);
    @(negedge clk); rst = 1'b1; in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_cpu_rst_n", cpu_rst_n, 0);
    chk("midrst_im_en", im_en, 0);
    chk("midrst_nwrites", wr_d.size(), 1);
    chk("midrst_w0", wr_d.size() > 0 ? wr_d[0] : 32'hX, 32'h44332211);
    repeat (3) @(negedge clk);
    chk("midrst_idle_cpu", cpu_rst_n, 0);
    clear_log();
    do_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    wait_end();
    chk("reload_nwrites", wr_d.size(), 1);
    chk("reload_pc0", wr_pc.size() > 0 ? wr_pc[0] : '1, 0);
    chk("reload_w0", wr_d.size() > 0 ? wr_d[0] : 32'hX, 32'h12345678);
    chk("reload_done_cnt", done_cnt, 1);
    chk("reload_cpu_rst_n", cpu_rst_n, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
